// File: rtl/amm_cmd_master.sv
// amm_cmd_master: Avalon-MM master that drains a host command FIFO onto the bus
// in strict order, tracks outstanding pipelined reads and returns read data with
// its address. Optional watchdog: define AMM_CMD_MASTER_TIMEOUT_EN.
module amm_cmd_master #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned CMD_DEPTH      = 8,
    parameter int unsigned MAX_PENDING    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cmd_valid,
    output logic                                 cmd_ready,
    input  logic                                 cmd_write,
    input  logic [ADDR_WIDTH-1:0]                cmd_addr,
    input  logic [DATA_WIDTH-1:0]                cmd_data,
    input  logic [DATA_WIDTH/8-1:0]              cmd_be,
    output logic                                 rsp_valid,
    output logic [ADDR_WIDTH-1:0]                rsp_addr,
    output logic [DATA_WIDTH-1:0]                rsp_data,
    output logic [ADDR_WIDTH-1:0]                amm_address,
    output logic                                 amm_write,
    output logic                                 amm_read,
    output logic [DATA_WIDTH-1:0]                amm_writedata,
    output logic [DATA_WIDTH/8-1:0]              amm_byteenable,
    input  logic [DATA_WIDTH-1:0]                amm_readdata,
    input  logic                                 amm_readdatavalid,
    input  logic                                 amm_waitrequest,
    output logic [$clog2(MAX_PENDING+1)-1:0]     pending_cnt,
    output logic [$clog2(CMD_DEPTH+1)-1:0]       cmd_cnt,
    output logic                                 busy,
    output logic                                 protocol_err
`ifdef AMM_CMD_MASTER_TIMEOUT_EN
    ,
    output logic                                 timeout
`endif
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH + BE_W;
    localparam int unsigned CPW   = $clog2(CMD_DEPTH);
    localparam int unsigned CCW   = $clog2(CMD_DEPTH + 1);
    localparam int unsigned PPW   = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam int unsigned PCW   = $clog2(MAX_PENDING + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [CMD_W-1:0]      r_cmd_mem [CMD_DEPTH];
    logic [CPW-1:0]        r_wr_ptr;
    logic [CPW-1:0]        r_rd_ptr;
    logic [CCW-1:0]        r_cmd_cnt;
    logic                  r_ready_en;
    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_amm_address;
    logic                  r_amm_write;
    logic                  r_amm_read;
    logic [DATA_WIDTH-1:0] r_amm_writedata;
    logic [BE_W-1:0]       r_amm_byteenable;
    logic [ADDR_WIDTH-1:0] r_pend_mem [MAX_PENDING];
    logic [PPW-1:0]        r_pend_wr;
    logic [PPW-1:0]        r_pend_rd;
    logic [PCW-1:0]        r_pend_cnt;
    logic                  r_rsp_valid;
    logic [ADDR_WIDTH-1:0] r_rsp_addr;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_perr;

    logic                  w_push;
    logic                  w_pop;
    logic [CMD_W-1:0]      w_head;
    logic                  w_head_wr;
    logic                  w_accept;
    logic                  w_rd_accept;
    logic [PCW-1:0]        w_pend_after;
    logic                  w_head_elig;
    logic                  w_rdv_ok;
    logic                  w_pend_push;
    logic                  w_timeout;
    logic [0:0]            w_state_nxt;

    // Handshake and eligibility terms derived from registered state
    assign cmd_ready    = r_ready_en && (r_cmd_cnt != CCW'(CMD_DEPTH));
    assign w_push       = cmd_valid && cmd_ready;
    assign w_head       = r_cmd_mem[r_rd_ptr];
    assign w_head_wr    = w_head[CMD_W-1];
    assign w_accept     = (r_state == S_ISSUE) && !amm_waitrequest;
    assign w_rd_accept  = w_accept && r_amm_read;
    // A read accepted this edge already occupies a pending slot
    assign w_pend_after = r_pend_cnt + PCW'(w_rd_accept);
    assign w_head_elig  = (r_cmd_cnt != '0) && (w_head_wr || (w_pend_after < PCW'(MAX_PENDING)));
    assign w_rdv_ok     = amm_readdatavalid && (r_pend_cnt != '0);
    assign w_pend_push  = w_rd_accept && !w_timeout;

    // Issue FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Issue FSM next state and FIFO pop decision
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_head_elig) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_accept) begin
                    if (w_head_elig) w_pop = 1'b1;
                    else             w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) begin
            w_pop       = 1'b0;
            w_state_nxt = S_IDLE;
        end
    end

    // Command FIFO storage
    always_ff @(posedge clk) begin
        if (w_push) r_cmd_mem[r_wr_ptr] <= {cmd_write, cmd_addr, cmd_data, cmd_be};
    end

    // Command FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cmd_cnt  <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + CPW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + CPW'(1);
            r_cmd_cnt <= r_cmd_cnt + CCW'(w_push) - CCW'(w_pop);
        end
    end

    // Avalon bus registers: load on pop, hold while stalled, clear when going idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_amm_address    <= '0;
            r_amm_write      <= 1'b0;
            r_amm_read       <= 1'b0;
            r_amm_writedata  <= '0;
            r_amm_byteenable <= '0;
        end else if (w_pop) begin
            r_amm_write      <= w_head_wr;
            r_amm_read       <= !w_head_wr;
            r_amm_address    <= w_head[CMD_W-2 -: ADDR_WIDTH];
            r_amm_writedata  <= w_head[DATA_WIDTH+BE_W-1 -: DATA_WIDTH];
            r_amm_byteenable <= w_head[BE_W-1:0];
        end else if (w_accept || w_timeout) begin
            r_amm_address    <= '0;
            r_amm_write      <= 1'b0;
            r_amm_read       <= 1'b0;
            r_amm_writedata  <= '0;
            r_amm_byteenable <= '0;
        end
    end

    // Pending-read address storage
    always_ff @(posedge clk) begin
        if (w_pend_push) r_pend_mem[r_pend_wr] <= r_amm_address;
    end

    // Pending-read pointers and count; watchdog expiry flushes them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_wr  <= '0;
            r_pend_rd  <= '0;
            r_pend_cnt <= '0;
        end else if (w_timeout) begin
            r_pend_wr  <= '0;
            r_pend_rd  <= '0;
            r_pend_cnt <= '0;
        end else begin
            if (w_pend_push)
                r_pend_wr <= (r_pend_wr == PPW'(MAX_PENDING-1)) ? '0 : r_pend_wr + PPW'(1);
            if (w_rdv_ok)
                r_pend_rd <= (r_pend_rd == PPW'(MAX_PENDING-1)) ? '0 : r_pend_rd + PPW'(1);
            r_pend_cnt <= r_pend_cnt + PCW'(w_pend_push) - PCW'(w_rdv_ok);
        end
    end

    // Read response and sticky protocol error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
            r_perr      <= 1'b0;
        end else begin
            r_rsp_valid <= w_rdv_ok;
            if (w_rdv_ok) begin
                r_rsp_addr <= r_pend_mem[r_pend_rd];
                r_rsp_data <= amm_readdata;
            end
            if ((amm_readdatavalid && (r_pend_cnt == '0)) || w_timeout) r_perr <= 1'b1;
        end
    end

`ifdef AMM_CMD_MASTER_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] r_wd_cnt;
    logic           r_timeout;
    logic           w_wd_run;
    logic           w_wd_restart;

    assign w_wd_run     = ((r_state == S_ISSUE) && amm_waitrequest) ||
                          ((r_pend_cnt != '0) && !amm_readdatavalid);
    assign w_wd_restart = w_accept || amm_readdatavalid;
    assign w_timeout    = w_wd_run && !w_wd_restart && (r_wd_cnt == WDW'(TIMEOUT_CYCLES-1));
    assign timeout      = r_timeout;

    // Watchdog counter over stalled issue or silent pending reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if (!w_wd_run || w_wd_restart || w_timeout) r_wd_cnt <= '0;
            else                                         r_wd_cnt <= r_wd_cnt + WDW'(1);
        end
    end
`else
    // Watchdog compiled out; the parameter stays referenced so builds share one interface
    assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    assign amm_address    = r_amm_address;
    assign amm_write      = r_amm_write;
    assign amm_read       = r_amm_read;
    assign amm_writedata  = r_amm_writedata;
    assign amm_byteenable = r_amm_byteenable;
    assign pending_cnt    = r_pend_cnt;
    assign cmd_cnt        = r_cmd_cnt;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_addr       = r_rsp_addr;
    assign rsp_data       = r_rsp_data;
    assign protocol_err   = r_perr;
    assign busy           = (r_cmd_cnt != '0) || (r_state == S_ISSUE) || (r_pend_cnt != '0);

endmodule
